// File: rtl/led_scroller_multi.sv
// led_scroller_multi: parametrised LED pattern generator with a programmable
// prescaler and four run-time modes (rotate left, rotate right, bounce, bar fill).
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   en       1 = prescaler advances and pattern steps, 0 = freeze
//   mode     00 rotate-left, 01 rotate-right, 10 bounce, 11 bar-fill
//   period   a step occurs every period+1 enabled cycles
//   restart  synchronous pulse: reseed pattern from mode, clear prescaler
//   leds     current pattern (registered)
//   step     one-cycle pulse coincident with each new leds value
//   wrap     one-cycle pulse when a pattern cycle completes
module led_scroller_multi #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] period,
    input  logic             restart,
    output logic [WIDTH-1:0] leds,
    output logic             step,
    output logic             wrap
);

    typedef enum logic [1:0] {
        MODE_ROL    = 2'b00,
        MODE_ROR    = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_BAR    = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    logic [DIV_W-1:0] cnt_q,  cnt_d;
    mode_e            mode_q, mode_d;
    dir_e             dir_q,  dir_d;
    logic [WIDTH-1:0] leds_q, leds_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] shifted_c;
    logic             step_cyc_c;

    // Initial pattern for a freshly selected mode; every seed starts a cycle.
    function automatic logic [WIDTH-1:0] seed(input mode_e m);
        logic [WIDTH-1:0] s;
        s = '0;
        case (m)
            MODE_ROL:    s[0]       = 1'b1;
            MODE_ROR:    s[WIDTH-1] = 1'b1;
            MODE_BOUNCE: s[0]       = 1'b1;
            default:     s          = '0;
        endcase
        return s;
    endfunction

    assign step_cyc_c = en && (cnt_q >= period);

    // Next-state and pulse logic; restart outranks a step cycle.
    always_comb begin
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        dir_d     = dir_q;
        leds_d    = leds_q;
        step_d    = 1'b0;
        wrap_d    = 1'b0;
        shifted_c = '0;

        if (restart) begin
            cnt_d  = '0;
            mode_d = mode_e'(mode);
            leds_d = seed(mode_e'(mode));
            dir_d  = DIR_LEFT;
        end else if (step_cyc_c) begin
            cnt_d  = '0;
            step_d = 1'b1;
            if (mode_e'(mode) != mode_q) begin
                // A mode change spends its step on reseeding, never advancing.
                mode_d = mode_e'(mode);
                leds_d = seed(mode_e'(mode));
                dir_d  = DIR_LEFT;
            end else begin
                case (mode_q)
                    MODE_ROL: begin
                        leds_d = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
                        wrap_d = leds_q[WIDTH-1];
                    end
                    MODE_ROR: begin
                        leds_d = {leds_q[0], leds_q[WIDTH-1:1]};
                        wrap_d = leds_q[0];
                    end
                    MODE_BOUNCE: begin
                        // Direction flips on arrival at an end so no end LED repeats.
                        if (dir_q == DIR_LEFT) begin
                            shifted_c = {leds_q[WIDTH-2:0], 1'b0};
                            if (shifted_c[WIDTH-1]) dir_d = DIR_RIGHT;
                        end else begin
                            shifted_c = {1'b0, leds_q[WIDTH-1:1]};
                            if (shifted_c[0]) begin
                                dir_d  = DIR_LEFT;
                                wrap_d = 1'b1;
                            end
                        end
                        leds_d = shifted_c;
                    end
                    default: begin
                        if (&leds_q) begin
                            leds_d = '0;
                            wrap_d = 1'b1;
                        end else begin
                            leds_d = {leds_q[WIDTH-2:0], 1'b1};
                        end
                    end
                endcase
            end
        end else if (en) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            mode_q <= MODE_ROL;
            dir_q  <= DIR_LEFT;
            leds_q <= WIDTH'(1);
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            dir_q  <= dir_d;
            leds_q <= leds_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
        end
    end

    assign leds = leds_q;
    assign step = step_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_led_scroller_multi.sv
// Testbench for led_scroller_multi: directed scenarios followed by random
// stimulus, checked against a position-index model of each pattern cycle.
module tb_led_scroller_multi;

    localparam int W  = 7;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [1:0]    mode;
    logic [DW-1:0] period;
    logic          restart;
    logic [W-1:0]  leds;
    logic          step;
    logic          wrap;

    int checks   = 0;
    int failures = 0;

    // Model: each mode is a cycle of positions 0..len-1; position 0 is the seed.
    int m_cnt;
    int m_mode;
    int m_idx;
    logic exp_step;
    logic exp_wrap;
    int n_steps;
    int n_wraps;

    led_scroller_multi #(.WIDTH(W), .DIV_W(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .mode    (mode),
        .period  (period),
        .restart (restart),
        .leds    (leds),
        .step    (step),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    function automatic int cyc_len(input int m);
        case (m)
            0, 1:    return W;
            2:       return 2 * (W - 1);
            default: return W + 1;
        endcase
    endfunction

    function automatic logic [W-1:0] pat(input int m, input int idx);
        logic [W-1:0] v;
        v = '0;
        case (m)
            0: v[idx] = 1'b1;
            1: v[W-1-idx] = 1'b1;
            2: if (idx < W) v[idx] = 1'b1; else v[2*(W-1)-idx] = 1'b1;
            default: for (int k = 0; k < idx; k++) v[k] = 1'b1;
        endcase
        return v;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt    = 0;
        m_mode   = 0;
        m_idx    = 0;
        exp_step = 1'b0;
        exp_wrap = 1'b0;
    endtask

    // One clock: advance the model from current inputs, then compare outputs.
    task automatic tick();
        exp_step = 1'b0;
        exp_wrap = 1'b0;
        if (restart) begin
            m_cnt  = 0;
            m_mode = int'(mode);
            m_idx  = 0;
        end else if (en) begin
            if (m_cnt >= int'(period)) begin
                m_cnt    = 0;
                exp_step = 1'b1;
                if (int'(mode) != m_mode) begin
                    m_mode = int'(mode);
                    m_idx  = 0;
                end else begin
                    m_idx    = (m_idx + 1) % cyc_len(m_mode);
                    exp_wrap = (m_idx == 0);
                end
            end else begin
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        chk("leds", leds, pat(m_mode, m_idx));
        chk("step", W'(step), W'(exp_step));
        chk("wrap", W'(wrap), W'(exp_wrap));
        if (step) n_steps++;
        if (wrap) n_wraps++;
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        mode    = 2'b00;
        period  = DW'(15);
        restart = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_leds", leds, W'(1));
        chk("reset_step", W'(step), W'(0));
        chk("reset_wrap", W'(wrap), W'(0));
        rst_n = 1'b1;

        // Slow rotate-left from reset: first step after 16 enabled cycles.
        en = 1'b1;
        repeat (15) tick();
        chk("rol_hold", leds, 7'b0000001);
        tick();
        chk("rol_first", leds, 7'b0000010);
        chk("rol_first_step", W'(step), W'(1));
        n_steps = 1;
        n_wraps = 0;
        repeat (6 * 16) tick();
        chk("rol_cycle_leds", leds, 7'b0000001);
        chk("rol_cycle_wrap", W'(wrap), W'(1));
        chk("rol_steps", W'(n_steps), W'(7));
        chk("rol_wraps", W'(n_wraps), W'(1));

        // Rotate-right at full speed: first step reseeds.
        period = '0;
        mode   = 2'b01;
        tick();
        chk("ror_seed", leds, 7'b1000000);
        chk("ror_seed_wrap", W'(wrap), W'(0));
        repeat (6) tick();
        chk("ror_end", leds, 7'b0000001);
        tick();
        chk("ror_wrap_leds", leds, 7'b1000000);
        chk("ror_wrap", W'(wrap), W'(1));

        // Bounce via restart: 12-step cycle.
        restart = 1'b1;
        mode    = 2'b10;
        tick();
        restart = 1'b0;
        chk("bnc_seed", leds, 7'b0000001);
        chk("bnc_seed_step", W'(step), W'(0));
        n_wraps = 0;
        repeat (6) tick();
        chk("bnc_top", leds, 7'b1000000);
        tick();
        chk("bnc_down", leds, 7'b0100000);
        repeat (5) tick();
        chk("bnc_back", leds, 7'b0000001);
        chk("bnc_wraps", W'(n_wraps), W'(1));

        // Bar fill: 8-step cycle.
        mode = 2'b11;
        tick();
        chk("bar_seed", leds, 7'b0000000);
        repeat (7) tick();
        chk("bar_full", leds, 7'b1111111);
        chk("bar_full_wrap", W'(wrap), W'(0));
        tick();
        chk("bar_empty", leds, 7'b0000000);
        chk("bar_wrap", W'(wrap), W'(1));

        // Freeze mid-period, change mode while frozen.
        period = DW'(3);
        mode   = 2'b00;
        repeat (6) tick();
        en = 1'b0;
        repeat (2) tick();
        mode = 2'b01;
        repeat (3) tick();
        en = 1'b1;
        repeat (10) tick();

        // Restart with en low mid-pattern.
        mode    = 2'b10;
        en      = 1'b0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("rst_en0_leds", leds, 7'b0000001);
        en = 1'b1;
        repeat (9) tick();

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_leds", leds, 7'b0000001);
        chk("async_step", W'(step), W'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) tick();

        // Random operation.
        for (int i = 0; i < 3000; i++) begin
            en      = ($urandom_range(0, 9) != 0);
            restart = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 29) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 39) == 0) period = DW'($urandom_range(0, 4));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_scroller_multi.md
Name: led_scroller_multi

Overview:
Parametrised LED pattern generator. It is the successor to the fixed 7-LED single-direction scroller. A programmable prescaler paces the pattern steps. Four run-time modes are supported: rotate left, rotate right, bounce and bar fill. Per-step and per-cycle status pulses are provided. The block drives the board LED bank directly or feeds an LED mux.

Parameters:
WIDTH, 7, number of LEDs; legal range >= 2
DIV_W, 4, prescaler counter and period input width

Ports:
clk  in  1  system clock; the only clock
rst_n  in  1  reset; asynchronous, active-low
en  in  1  1 = prescaler advances and pattern steps; 0 = freeze
mode  in  2  00 rotate-left, 01 rotate-right, 10 bounce, 11 bar-fill
period  in  DIV_W  step occurs every period+1 enabled cycles
restart  in  1  synchronous pulse: reseed pattern, clear prescaler
leds  out  WIDTH  current pattern, registered
step  out  1  one-cycle pulse, coincident with each new leds value
wrap  out  1  one-cycle pulse when a pattern cycle completes

Behaviour:
- Reset (rst_n low, async) sets: leds = 1 (bit 0 only), internal mode_q = 00, bounce dir = left, prescaler cnt = 0, step = 0, wrap = 0.
- Prescaler:
  - If en = 1 and cnt >= period: this is a step cycle; cnt <= 0.
  - If en = 1 and cnt < period: cnt <= cnt + 1.
  - If en = 0: cnt holds.
  - The >= compare means lowering period below cnt steps on the next enabled cycle.
  - period = 0 steps every enabled cycle.
- Priority: rst_n > restart > step cycle > hold.
- restart = 1, regardless of en:
  - cnt <= 0, mode_q <= mode, leds <= seed(mode), dir <= left.
  - step = 0 and wrap = 0 on the following cycle.
- Seeds: 00 -> bit 0; 01 -> bit WIDTH-1; 10 -> bit 0; 11 -> all zeros.
- mode is sampled only on step cycles.
- Step cycle where mode != mode_q:
  - mode_q <= mode, leds <= seed(mode), dir <= left.
  - step pulses; wrap = 0.
  - No pattern advance on that step.
- Step cycle where mode == mode_q advances leds by mode_q:
  - 00: rotate left by 1, so bit WIDTH-1 moves to bit 0. wrap pulses when old leds[WIDTH-1] = 1.
  - 01: rotate right by 1. wrap pulses when old leds[0] = 1.
  - 10, dir left: shift left; if new leds[WIDTH-1] = 1, dir <= right.
  - 10, dir right: shift right; if new leds[0] = 1, dir <= left and wrap pulses.
  - 10 cycle length is 2*(WIDTH-1) steps; the end LEDs are shown once per pass.
  - 11: if old leds is all ones, leds <= 0 and wrap pulses. Otherwise leds <= {leds[WIDTH-2:0], 1}. Cycle length is WIDTH+1 steps.
- step and wrap are registered: high for exactly one cycle, in the same cycle the new leds value first appears. Latency from step cycle to visible leds change is 1 clock.
- No combinational path from any input to any output.
- en falling mid-period freezes cnt. Counting resumes from the same cnt; there is no extra or lost step.
- Reset asserted mid-operation returns all state to reset values immediately. The first step after release needs period+1 enabled cycles.

Test Plan:
- WIDTH=7, period=15, mode=00, en=1 from reset -> leds 0000001 for 16 cycles, then 0000010 with step pulse. After 7 steps leds = 0000001 with wrap pulse; no wrap on the other 6 steps.
- period=0, mode=01 (first step reseeds to 1000000 with step, wrap=0) -> subsequent steps every cycle: 0100000, 0010000 ... 0000001, then 1000000 with wrap.
- period=0, restart then mode=10 -> sequence 1,2,4,8,16,32,64,32,...,2,1. wrap only on the return to 1, every 12 steps. dir flips without repeating 64.
- mode=11, period=0 -> 0,1,3,7,15,31,63,127,0. wrap on the 127->0 step only, every 8 steps.
- Mid-pattern, drop en for 5 cycles, then change mode between steps -> leds and cnt frozen while en=0, step=0. The change takes effect only at the next step, as reseed with wrap=0.
- Assert restart and en=0 together mid-pattern -> leds = seed(mode) next cycle and cnt = 0; step and wrap stay 0.
- Pulse rst_n low asynchronously between clock edges -> leds = 0000001 immediately.
